// File: rtl/probe_pkg.sv
// Shared types and constants for the probe port arbiter.
package probe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK1 = 2'd1,
    MARK2 = 2'd2,
    SHOW  = 2'd3
  } state_t;

  // Upper nibble of the second marker byte; the lower nibble carries src_id.
  localparam logic [3:0] MARK2_NIB     = 4'h5;
  localparam logic [7:0] DEF_MARK_BYTE = 8'hA5;

endpackage

// File: rtl/probe_rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1, wrapping.
module probe_rr_pick #(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]         req,
  input  logic [$clog2(N_SRC)-1:0] last,
  output logic [$clog2(N_SRC)-1:0] win,
  output logic                     any
);

  localparam int IW = $clog2(N_SRC);

  int          pos;
  logic [IW-1:0] idx;

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  // The previous grantee (offset N_SRC) is only picked when nobody else asks.
  always_comb begin
    win = '0;
    any = |req;
    pos = 0;
    idx = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      pos = (int'(last) + k) % N_SRC;
      idx = IW'(pos);
      if (req[idx]) win = idx;
    end
  end

endmodule

// File: rtl/probe_port_arbiter.sv
// Time-shares the 8-bit probe port among debug sources, with a marker frame
// ahead of every newly granted source and a minimum hold per grant.
module probe_port_arbiter
  import probe_pkg::*;
#(
  parameter int         N_SRC       = 4,
  parameter int         HOLD_CYCLES = 16,
  parameter logic [7:0] MARK_BYTE   = DEF_MARK_BYTE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         req,
  input  logic [8*N_SRC-1:0]       data,
  output logic [N_SRC-1:0]         grant,
  output logic [7:0]               port,
  output logic                     active,
  output logic [$clog2(N_SRC)-1:0] src_id
);

  localparam int IW = $clog2(N_SRC);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  state_t                  state, state_nx;
  logic [IW-1:0]           last, last_nx, sel_nx;
  logic [HW-1:0]           hold, hold_nx;
  logic [IW-1:0]           win;
  logic                    any;
  logic [N_SRC-1:0][7:0]   data_arr;
  logic [N_SRC-1:0]        grant_nx;
  logic [7:0]              port_nx;
  logic [3:0]              sel_nib;

  assign data_arr = data;

  probe_rr_pick #(.N_SRC(N_SRC)) u_pick (
    .req  (req),
    .last (last),
    .win  (win),
    .any  (any)
  );

  // Next state, grantee and hold counter; requests only matter in IDLE and
  // in SHOW once the hold window has run out.
  always_comb begin
    state_nx = state;
    last_nx  = last;
    sel_nx   = src_id;
    hold_nx  = hold;
    case (state)
      IDLE: begin
        if (any) begin
          state_nx = MARK1;
          sel_nx   = win;
          last_nx  = win;
        end
      end
      MARK1: state_nx = MARK2;
      MARK2: begin
        state_nx = SHOW;
        hold_nx  = HW'(HOLD_CYCLES - 1);
      end
      SHOW: begin
        if (hold != '0) begin
          hold_nx = hold - 1'b1;
        end else if (!any) begin
          state_nx = IDLE;
        end else if (win != src_id) begin
          // Sole-requester case picks the current source and just stays.
          state_nx = MARK1;
          sel_nx   = win;
          last_nx  = win;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    port_nx  = 8'h00;
    grant_nx = '0;
    sel_nib  = 4'(sel_nx);
    case (state_nx)
      MARK1: port_nx = MARK_BYTE;
      MARK2: port_nx = {MARK2_NIB, sel_nib};
      SHOW: begin
        port_nx          = data_arr[sel_nx];
        grant_nx[sel_nx] = 1'b1;
      end
      default: port_nx = 8'h00;
    endcase
  end

  // State and output registers; last starts at N_SRC-1 so source 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last   <= IW'(N_SRC - 1);
      hold   <= '0;
      src_id <= '0;
      port   <= 8'h00;
      grant  <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_nx;
      last   <= last_nx;
      hold   <= hold_nx;
      src_id <= sel_nx;
      port   <= port_nx;
      grant  <= grant_nx;
      active <= (state_nx != IDLE);
    end
  end

endmodule

// File: doc/probe_port_arbiter.md
# probe_port_arbiter

Shares the single 8-bit logic-analyser probe port among up to N_SRC internal debug sources (free-running counters, CPU bus fields, FSM state vectors). It grants one source at a time with round-robin fairness and a guaranteed minimum hold time. Before each new source appears, it emits a two-byte marker frame so captures can be decoded offline. The block sits between the debug taps and the top-level `port[7:0]` pins, in the PLL-derived low-speed clock domain.

## Interface
- N_SRC, 4, number of requesting sources (2..16)
- HOLD_CYCLES, 16, minimum cycles a granted source stays on the port (≥1)
- MARK_BYTE, 8'hA5, first marker byte
- clk  input  1  clock (low-speed PLL output); one clock domain only
- rst  input  1  reset, asynchronous, active-high
- req  input  N_SRC  per-source request to be shown on the port
- data  input  8*N_SRC  source i drives bits [8i+7:8i]
- grant  output  N_SRC  one-hot; bit i high while source i is on the port
- port  output  8  probe pins, registered
- active  output  1  high in MARK1, MARK2 and SHOW
- src_id  output  $clog2(N_SRC)  index of the current or most recent grantee

## Operation
- States:
  - IDLE: port=0, grant=0.
  - MARK1: port=MARK_BYTE.
  - MARK2: port={4'h5, src_id zero-extended to 4 bits}.
  - SHOW: port=data[src_id], grant[src_id]=1.
- Round-robin pointer `last` holds the most recent grantee. The search starts at last+1 and wraps modulo N_SRC. Requests are sampled only at arbitration points.
- Arbitration points:
  - In IDLE, on every cycle.
  - In SHOW, once the hold counter is 0.
- IDLE with any req: pick winner w, set src_id=w and last=w, go to MARK1.
- MARK1 always goes to MARK2. MARK2 always goes to SHOW. Requests are ignored during both states.
- On SHOW entry, the hold counter loads HOLD_CYCLES-1 and decrements each cycle, saturating at 0.
- SHOW with hold counter 0:
  - Another source requesting: pick winner via round-robin and go to MARK1. The current source is eligible only if it is the sole requester.
  - Only the current source requesting: stay in SHOW. No marker is emitted and the counter is not reloaded.
  - No requests: go to IDLE.
- A req drop during the hold window has no effect. The source stays shown until the counter reaches 0.
- If the winner is the same index as the previous grantee after passing through IDLE, the full marker frame is still emitted.

## Timing
- All outputs are registered. Reset values:
  - port=8'h00, grant=0, active=0, src_id=0
  - state=IDLE, last=N_SRC-1 (so source 0 wins first), hold counter=0
- Asynchronous reset takes effect immediately in any state, including mid-marker and mid-hold. After reset release, the first arbitration is at the next edge.
- Latency from IDLE:
  - req sampled at edge E0.
  - After E0: port=MARK_BYTE.
  - After E1: port=marker byte 2.
  - After E2: grant valid and port=data[w] as sampled at E2.
- SHOW tracking: port follows data with exactly one cycle of latency. A data change at edge En appears after En+1.
- A source is shown for at least HOLD_CYCLES cycles. Each switch between sources costs exactly 2 marker cycles, during which grant=0.
- A switch from SHOW to MARK1 happens at the edge where the counter is 0. The last SHOW cycle is the one with counter==0.
- All req bits rising in the same cycle: the lowest index at or after last+1 wins.

## Structure
- Package `probe_pkg` holds:
  - the state enum (IDLE, MARK1, MARK2, SHOW)
  - the marker-2 nibble constant 4'h5
  - the default MARK_BYTE
- One sub-module, `probe_rr_pick`. It is combinational: inputs are req and last, outputs are the winner index and an any-request flag. The arbiter instantiates it once.
- The hold counter width is $clog2(HOLD_CYCLES+1).

## Test plan
- **Reset mid-operation:** assert rst during MARK2 with port=8'h51, then release. port=0, grant=0 and active=0 immediately. A later req[0] produces port sequence A5, 50, data0.
- **Single request from IDLE:** req=4'b0100, data2=8'h3C. Port shows A5, 52, 3C on consecutive cycles. grant=4'b0100 from the third cycle. The port holds 3C for at least 16 cycles.
- **Round-robin rotation:** req=4'b1111 held, HOLD_CYCLES=4. Grant order is 0,1,2,3,0. Each SHOW lasts exactly 4 cycles and is separated by 2 marker cycles.
- **Hold-window drop:** req[1] pulses high for 1 cycle. Source 1 stays granted for 16 cycles, then the block returns to IDLE with port=0.
- **Sole requester persists:** req=4'b0001 held for 100 cycles. Exactly one marker frame is emitted, grant stays at 4'b0001, and port tracks data0 with 1-cycle latency.
